// File: rtl/prime_test_pkg.sv
// Shared types and constants for the prime test responder: FSM states and the
// starting divisor/square used once the trivial cases have been ruled out.
package prime_test_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    LOOP_TEST,
    MOD_START,
    MOD_WAIT,
    DONE
  } state_e;

  localparam int unsigned D_INIT  = 3;
  localparam int unsigned SQ_INIT = 9;

endpackage

// File: rtl/prime_test_unit_urem.sv
// Restoring unsigned remainder unit, one quotient bit per cycle; done pulses
// exactly WIDTH cycles after start with the final remainder on rem.
module seq_urem #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // The partial remainder stays below the divisor, so after the conditional
  // subtract it always fits back into WIDTH bits.
  function automatic logic [WIDTH-1:0] urem_step(input logic [WIDTH-1:0] r,
                                                 input logic             b,
                                                 input logic [WIDTH-1:0] dv);
    logic [WIDTH:0] p;
    p = {r, b};
    if (p >= {1'b0, dv}) p = p - {1'b0, dv};
    return p[WIDTH-1:0];
  endfunction

  always_comb begin
    rem_d  = rem_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    // The first bit is consumed on the start edge so done lands on cycle WIDTH.
    if (start) begin
      rem_d  = urem_step('0, dividend[WIDTH-1], divisor);
      dvd_d  = dividend << 1;
      dvs_d  = divisor;
      cnt_d  = CW'(WIDTH - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = urem_step(rem_q, dvd_q[WIDTH-1], dvs_q);
      dvd_d = dvd_q << 1;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign rem  = rem_q;
  assign done = done_q;

endmodule

// File: rtl/prime_test_unit.sv
// Primality-test callee for the req/busy/return handshake, trial dividing by
// odd d while d*d <= n, plus a writable counter of prime results.
module prime_test_unit
  import prime_test_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] test_n,
  input  logic             test_req,
  output logic             test_busy,
  output logic             test_return,
  input  logic [31:0]      found_in,
  input  logic             found_we,
  output logic [31:0]      found_out
);

  localparam int W2 = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [W2-1:0]    sq_q, sq_d;
  logic             result_q, result_d;
  logic             busy_q, busy_d;
  logic             ret_q, ret_d;
  logic [31:0]      found_q, found_d;

  logic             urem_start;
  logic [WIDTH-1:0] urem_rem;
  logic             urem_done;

  assign urem_start = (state_q == MOD_START);

  seq_urem #(.WIDTH(WIDTH)) u_urem (
    .clk      (clk),
    .reset    (reset),
    .start    (urem_start),
    .dividend (n_q),
    .divisor  (d_q),
    .rem      (urem_rem),
    .done     (urem_done)
  );

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    d_d      = d_q;
    sq_d     = sq_q;
    result_d = result_q;
    busy_d   = busy_q;
    ret_d    = ret_q;
    found_d  = found_q;
    unique case (state_q)
      IDLE: begin
        if (test_req) begin
          n_d     = test_n;
          busy_d  = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = DONE;
        if (n_q < WIDTH'(2)) begin
          result_d = 1'b0;
        end else if (n_q == WIDTH'(2) || n_q == WIDTH'(3)) begin
          result_d = 1'b1;
        end else if (!n_q[0]) begin
          result_d = 1'b0;
        end else begin
          d_d     = WIDTH'(D_INIT);
          sq_d    = W2'(SQ_INIT);
          state_d = LOOP_TEST;
        end
      end
      LOOP_TEST: begin
        if (sq_q > {{WIDTH{1'b0}}, n_q}) begin
          result_d = 1'b1;
          state_d  = DONE;
        end else begin
          state_d = MOD_START;
        end
      end
      MOD_START: state_d = MOD_WAIT;
      MOD_WAIT: begin
        // (d+2)^2 = d^2 + 4d + 4, so the square tracks d without a multiplier.
        if (urem_done) begin
          if (urem_rem == '0) begin
            result_d = 1'b0;
            state_d  = DONE;
          end else begin
            d_d     = d_q + WIDTH'(2);
            sq_d    = sq_q + ({{WIDTH{1'b0}}, d_q} << 2) + W2'(4);
            state_d = LOOP_TEST;
          end
        end
      end
      DONE: begin
        ret_d   = result_q;
        busy_d  = 1'b0;
        state_d = IDLE;
        if (result_q) found_d = found_q + 32'd1;
      end
      default: state_d = IDLE;
    endcase
    if (found_we) found_d = found_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      n_q      <= '0;
      d_q      <= '0;
      sq_q     <= '0;
      result_q <= 1'b0;
      busy_q   <= 1'b0;
      ret_q    <= 1'b0;
      found_q  <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      d_q      <= d_d;
      sq_q     <= sq_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      ret_q    <= ret_d;
      found_q  <= found_d;
    end
  end

  assign test_busy   = busy_q;
  assign test_return = ret_q;
  assign found_out   = found_q;

endmodule

// File: tb/tb_prime_test_unit.sv
// Directed bench for prime_test_unit: busy duration, result and prime counter
// for trivial, looping, back-to-back, field-write and mid-call reset cases.
module tb_prime_test_unit;

  logic        clk;
  logic        reset;
  logic [31:0] test_n;
  logic        test_req;
  logic        test_busy;
  logic        test_return;
  logic [31:0] found_in;
  logic        found_we;
  logic [31:0] found_out;

  int nCompared;
  int nMismatched;

  prime_test_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .test_n      (test_n),
    .test_req    (test_req),
    .test_busy   (test_busy),
    .test_return (test_return),
    .found_in    (found_in),
    .found_we    (found_we),
    .found_out   (found_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one call and counts sampled busy-high cycles, bounded by a budget.
  task automatic doCall(input logic [31:0] n, input bit hold,
                        output int cycles, output logic ret);
    test_n   = n;
    test_req = 1'b1;
    @(posedge clk); #1;
    if (!hold) test_req = 1'b0;
    cycles = 0;
    while (test_busy === 1'b1 && cycles < 1000) begin
      cycles++;
      @(posedge clk); #1;
    end
    ret = test_return;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    nCompared++;
    if (test_busy !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_busy: got %0b expected 0", test_busy);
    end
    nCompared++;
    if (test_return !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_return: got %0b expected 0", test_return);
    end
    nCompared++;
    if (found_out !== 32'd0) begin
      nMismatched++;
      $display("[TB] FAIL reset_found: got %0d expected 0", found_out);
    end
  endtask

  task automatic test_back_to_back();
    int   cyc;
    logic ret;
    doCall(32'd7, 1'b1, cyc, ret);
    nCompared++;
    if (cyc != 3) begin
      nMismatched++;
      $display("[TB] FAIL b2b_first_cycles: got %0d expected 3", cyc);
    end
    nCompared++;
    if (ret !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL b2b_first_return: got %0b expected 1", ret);
    end
    nCompared++;
    if (found_out !== 32'd1) begin
      nMismatched++;
      $display("[TB] FAIL b2b_first_found: got %0d expected 1", found_out);
    end
    @(posedge clk); #1;
    test_req = 1'b0;
    nCompared++;
    if (test_busy !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL b2b_gap_one_cycle: got busy %0b expected 1", test_busy);
    end
    cyc = 0;
    while (test_busy === 1'b1 && cyc < 1000) begin
      cyc++;
      @(posedge clk); #1;
    end
    nCompared++;
    if (cyc != 3) begin
      nMismatched++;
      $display("[TB] FAIL b2b_second_cycles: got %0d expected 3", cyc);
    end
    nCompared++;
    if (found_out !== 32'd2) begin
      nMismatched++;
      $display("[TB] FAIL b2b_second_found: got %0d expected 2", found_out);
    end
  endtask

  task automatic test_composite_9();
    int   cyc;
    logic ret;
    doCall(32'd9, 1'b0, cyc, ret);
    nCompared++;
    if (cyc != 36) begin
      nMismatched++;
      $display("[TB] FAIL n9_cycles: got %0d expected 36", cyc);
    end
    nCompared++;
    if (ret !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL n9_return: got %0b expected 0", ret);
    end
    nCompared++;
    if (found_out !== 32'd2) begin
      nMismatched++;
      $display("[TB] FAIL n9_found: got %0d expected 2", found_out);
    end
  endtask

  task automatic test_prime_97();
    int   cyc;
    logic ret;
    doCall(32'd97, 1'b0, cyc, ret);
    nCompared++;
    if (cyc != 139) begin
      nMismatched++;
      $display("[TB] FAIL n97_cycles: got %0d expected 139", cyc);
    end
    nCompared++;
    if (ret !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL n97_return: got %0b expected 1", ret);
    end
    nCompared++;
    if (found_out !== 32'd3) begin
      nMismatched++;
      $display("[TB] FAIL n97_found: got %0d expected 3", found_out);
    end
  endtask

  task automatic test_trivial();
    logic [31:0] nVec [4]   = '{32'd0, 32'd1, 32'd2, 32'd4};
    logic        expRet [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int   cyc;
    logic ret;
    for (int i = 0; i < 4; i++) begin
      doCall(nVec[i], 1'b0, cyc, ret);
      nCompared++;
      if (cyc != 2) begin
        nMismatched++;
        $display("[TB] FAIL trivial_cycles n=%0d: got %0d expected 2", nVec[i], cyc);
      end
      nCompared++;
      if (ret !== expRet[i]) begin
        nMismatched++;
        $display("[TB] FAIL trivial_return n=%0d: got %0b expected %0b", nVec[i], ret, expRet[i]);
      end
    end
    nCompared++;
    if (found_out !== 32'd4) begin
      nMismatched++;
      $display("[TB] FAIL trivial_found: got %0d expected 4", found_out);
    end
  endtask

  task automatic test_field_write();
    int   cyc;
    logic ret;
    found_in = 32'd5;
    found_we = 1'b1;
    @(posedge clk); #1;
    found_we = 1'b0;
    nCompared++;
    if (found_out !== 32'd5) begin
      nMismatched++;
      $display("[TB] FAIL field_load: got %0d expected 5", found_out);
    end
    found_in = 32'd100;
    found_we = 1'b1;
    doCall(32'd2, 1'b0, cyc, ret);
    found_we = 1'b0;
    nCompared++;
    if (ret !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL field_call_return: got %0b expected 1", ret);
    end
    nCompared++;
    if (found_out !== 32'd100) begin
      nMismatched++;
      $display("[TB] FAIL field_write_wins: got %0d expected 100", found_out);
    end
  endtask

  task automatic test_reset_mid_call();
    int   cyc;
    logic ret;
    test_n   = 32'd25;
    test_req = 1'b1;
    @(posedge clk); #1;
    test_req = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    nCompared++;
    if (test_busy !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL midcall_busy_before: got %0b expected 1", test_busy);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    nCompared++;
    if (test_busy !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL midcall_reset_busy: got %0b expected 0", test_busy);
    end
    nCompared++;
    if (test_return !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL midcall_reset_return: got %0b expected 0", test_return);
    end
    nCompared++;
    if (found_out !== 32'd0) begin
      nMismatched++;
      $display("[TB] FAIL midcall_reset_found: got %0d expected 0", found_out);
    end
    doCall(32'd25, 1'b0, cyc, ret);
    nCompared++;
    if (cyc != 70) begin
      nMismatched++;
      $display("[TB] FAIL n25_cycles: got %0d expected 70", cyc);
    end
    nCompared++;
    if (ret !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL n25_return: got %0b expected 0", ret);
    end
    nCompared++;
    if (found_out !== 32'd0) begin
      nMismatched++;
      $display("[TB] FAIL n25_found: got %0d expected 0", found_out);
    end
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    reset    = 1'b1;
    test_n   = '0;
    test_req = 1'b0;
    found_in = '0;
    found_we = 1'b0;
    test_reset();
    test_back_to_back();
    test_composite_9();
    test_prime_97();
    test_trivial();
    test_field_write();
    test_reset_mid_call();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/prime_test_unit.md
# prime_test_unit

Hand-written hardware responder for the method-call handshake (`*_req` / `*_busy` / `*_return`) used by our generated cores. It implements an unsigned primality test: a caller holds `test_req` and waits for `test_busy` to fall, then reads `test_return`. It also exposes a writable field of the same style (`*_in` / `*_we` / `*_out`) that counts the primes found. The block serves as a drop-in callee for generated initiators and as a golden model for PrimeSim-style benches.

## Interface
- `WIDTH`, 32: width of the argument, the divisor and the remainder.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `test_n`  in  WIDTH  unsigned argument, sampled when a call is accepted.
- `test_req`  in  1  call request, level-sensitive.
- `test_busy`  out  1  high while a call is in progress (registered).
- `test_return`  out  1  result: 1 means prime. Valid while `test_busy`=0; holds its value until the next call completes.
- `found_in`  in  32  field write data.
- `found_we`  in  1  field write enable.
- `found_out`  out  32  field value: the number of completed calls that returned 1.

## Operation
- **Reset values:** `test_busy`=0, `test_return`=0, `found_out`=0, state IDLE.
- **IDLE:** if `test_req`=1, latch `n`=`test_n`, set `test_busy` to 1 and go to CHECK. Otherwise stay in IDLE.
- **CHECK:** resolves the trivial cases, then goes to DONE.
  - n<2 gives 0.
  - n==2 or n==3 gives 1.
  - n even gives 0.
  - Any other n sets d=3 and sq=9, then goes to LOOP_TEST.
- **LOOP_TEST:** if sq>n, result=1 and go to DONE. Otherwise go to MOD_START.
  - sq is 2·WIDTH bits wide, so the comparison cannot overflow.
- **MOD_START:** pulse `start` to `seq_urem` with (n, d) for one cycle.
- **MOD_WAIT:** wait for `done`.
  - rem==0 gives result=0 and go to DONE.
  - Otherwise update d+=2 and sq+=4·d+4 (using the old d), then go to LOOP_TEST.
- **DONE:**
  - `test_return`<=result and `test_busy`<=0, then go to IDLE.
  - If result=1, `found_out` is incremented (wraps at 2^32).
- **Back-to-back calls:** if `test_req` is still high, the next call is accepted on the following IDLE cycle. `test_busy` is therefore low for exactly one cycle between calls.
- **Field write:** `found_we`=1 loads `found_in` in any state. If it coincides with the DONE increment, the write wins.
- **Ignored inputs:** `test_n` and `test_req` are ignored while busy.
- **Reset mid-call:** the call is aborted and all reset values are restored. The `seq_urem` state is also cleared.

## Timing
- Call accepted at cycle 0 (IDLE with `test_req`=1). `test_busy` is 1 from cycle 1.
- Each divisor iteration takes exactly WIDTH+2 cycles: LOOP_TEST 1, MOD_START 1, MOD_WAIT WIDTH.
- `seq_urem` is a restoring divider, one quotient bit per cycle. `done` is asserted WIDTH cycles after `start`.
- Busy high-time, where k is the number of divisors tried:
  - trivial cases: 2 cycles.
  - loop ends on sq>n: k·(WIDTH+2)+3 cycles.
  - loop ends on a zero remainder: k·(WIDTH+2)+2 cycles.
- `test_return` and `found_out` update in the same edge that drops `test_busy`.

## Structure
- **`prime_test_pkg`:** state enum (IDLE, CHECK, LOOP_TEST, MOD_START, MOD_WAIT, DONE) and the constants for the initial d=3 and sq=9.
- **Sub-module `seq_urem`:** parameterised by WIDTH.
  - Ports: `clk`, `reset`, `start`, `dividend`, `divisor`, `rem`, `done`.
  - `done` is a one-cycle pulse.

## Test plan
- n=7, hold req (WIDTH=32) -> busy rises 1 cycle after acceptance and stays high 3 cycles; return=1; found_out=1.
- n=9 -> busy high 36 cycles; return=0; found_out unchanged.
- n=97 -> busy high 139 cycles (divisors 3, 5, 7, 9; sq=121 ends the loop); return=1.
- n ∈ {0, 1, 2, 4} -> busy high 2 cycles each; returns 0, 0, 1, 0.
- With found_out=5, n=2 completing while found_we=1 and found_in=100 -> found_out=100.
- Reset asserted mid-call for n=25 -> next cycle busy=0, return=0, found_out=0; a new n=25 call then returns 0 after 70 busy cycles.
